// File: rtl/mul_sequencer_if.sv
// Handshake and operand bus between the instruction decoder and the
// iterative multiplier sequencer.
interface mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             Flush;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             Busy;
  logic             Done;
  logic             Stall;
  logic [WIDTH-1:0] Result;
  logic             FlagN;
  logic             FlagZ;

  modport master (
    output Start, Flush, SrcA, SrcB,
    input  Busy, Done, Stall, Result, FlagN, FlagZ
  );

  modport slave (
    input  Start, Flush, SrcA, SrcB,
    output Busy, Done, Stall, Result, FlagN, FlagZ
  );
endinterface

// File: rtl/mul_sequencer.sv
// Shift-add multiplier for MUL: one multiplier bit per RUN cycle, ending
// early once the remaining multiplier bits are all zero.
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  mul_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] mcand_reg, mcand_next;
  logic [WIDTH-1:0] mplier_reg, mplier_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      acc_reg    <= acc_next;
      result_reg <= result_next;
    end
  end

  assign accept = (state_reg == IDLE) || (state_reg == DONE);

  always_comb begin
    state_next  = state_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    acc_next    = acc_reg;
    result_next = result_reg;

    if (bus.Flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (bus.Start) begin
            mcand_next  = bus.SrcA;
            mplier_next = bus.SrcB;
            acc_next    = '0;
            state_next  = RUN;
          end else begin
            state_next  = IDLE;
          end
        end
        RUN: begin
          // An exhausted multiplier means acc already holds the product.
          if (mplier_reg == '0) begin
            result_next = acc_reg;
            state_next  = DONE;
          end else begin
            if (mplier_reg[0]) begin
              acc_next = acc_reg + mcand_reg;
            end
            mcand_next  = mcand_reg << 1;
            mplier_next = mplier_reg >> 1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign bus.Busy   = (state_reg == RUN);
  assign bus.Done   = (state_reg == DONE);
  assign bus.Stall  = bus.Busy | (bus.Start & accept);
  assign bus.Result = result_reg;
  assign bus.FlagN  = result_reg[WIDTH-1];
  assign bus.FlagZ  = (result_reg == '0);

endmodule
